// File: rtl/serterm_pkg.sv
// rtl/serterm_pkg.sv - shared serial-terminal constants, arbiter state encoding and helpers
package serterm_pkg;

    localparam int BYTE_W = 8;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    // CH9350 frame header bytes, also used by the key-frame parser
    localparam logic [7:0] CH9350_HDR0 = 8'h57;
    localparam logic [7:0] CH9350_HDR1 = 8'hAB;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker: first request at or after pointer
module rr_pick
    import serterm_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    // One spare bit so ptr+offset cannot overflow before the explicit wrap at N
    localparam int SW = IW + 1;

    logic [SW-1:0] slot;
    logic          found;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        slot      = '0;
        for (int i = 0; i < N; i++) begin
            slot = {1'b0, ptr_i} + SW'(i);
            if (slot >= SW'(N)) begin
                slot = slot - SW'(N);
            end
            if (!found && req_i[slot[IW-1:0]]) begin
                found                      = 1'b1;
                gnt_idx_o                  = slot[IW-1:0];
                gnt_oh_o[slot[IW-1:0]]     = 1'b1;
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter in front of the UART TX byte stream
// Optional stall-release watchdog enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import serterm_pkg::*;
#(
    parameter int N       = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N*BYTE_W-1:0] s_axis_tdata,
    input  logic [N-1:0]        s_axis_tvalid,
    input  logic [N-1:0]        s_axis_tlast,
    output logic [N-1:0]        s_axis_tready,
    output logic [BYTE_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [N-1:0]        o_grant,
    output logic                o_busy,
    output logic                o_timeout
);

    localparam int IW = clog2(N);

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] next_ptr;

    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          lock;
    logic          g_valid;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i     (s_axis_tvalid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .gnt_vld_o (pick_vld)
    );

    assign lock          = (state_q == ARB_LOCK);
    assign g_valid       = lock & s_axis_tvalid[gidx_q];
    assign m_axis_tvalid = g_valid;
    assign m_axis_tdata  = lock ? s_axis_tdata[{gidx_q, 3'b000} +: BYTE_W] : '0;
    // grant_q is all-zero outside LOCK, so the ready decode needs no state term
    assign s_axis_tready = grant_q & {N{m_axis_tready}};
    assign next_ptr      = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
    assign o_grant       = grant_q;
    assign o_busy        = lock;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_LOCK;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                end
            end
            ARB_LOCK: begin
                if (g_valid && m_axis_tready && s_axis_tlast[gidx_q]) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
                end else if (!g_valid) begin
                    if (stall_q == CW'(TIMEOUT - 1)) begin
                        state_d   = ARB_IDLE;
                        grant_d   = '0;
                        ptr_d     = next_ptr;
                        stall_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        stall_d = stall_q + CW'(1);
                    end
                end else begin
                    stall_d = '0;
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a packet-level round-robin model
module tb_uart_tx_arbiter;
    import serterm_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [23:0] s_data = '0;
    logic [2:0]  s_valid = '0;
    logic [2:0]  s_last = '0;
    logic [2:0]  s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [2:0]  grant;
    logic        busy;
    logic        tmo;

    uart_tx_arbiter #(.N(3), .TIMEOUT(1024)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_timeout     (tmo)
    );

    always #5 i_clk = ~i_clk;

    logic [8:0] src_q[3][$];
    logic [9:0] obs_q[$];
    int         obs_cyc[$];
    logic [9:0] exp_q[$];
    logic       exp_last[$];
    bit         en[3];
    int         cyc;
    int         tready_mode;
    int         model_ptr;
    int         checks;
    int         errors;

    function automatic logic [1:0] oh2idx(input logic [2:0] g);
        case (g)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic bit pending();
        for (int k = 0; k < 3; k++) if (en[k] && src_q[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                s_valid[k]       = 1'b1;
                s_data[8*k +: 8] = src_q[k][0][7:0];
                s_last[k]        = src_q[k][0][8];
            end else begin
                s_valid[k]       = 1'b0;
                s_data[8*k +: 8] = 8'h00;
                s_last[k]        = 1'b0;
            end
        end
        case (tready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = cyc[0];
            default: m_ready = ($urandom % 4) != 0;
        endcase
    endtask

    // Observe at the falling edge, advance sources just after the rising edge
    task automatic step();
        @(negedge i_clk);
        if (m_valid && m_ready) begin
            obs_q.push_back({oh2idx(grant), m_data});
            obs_cyc.push_back(cyc);
        end
        for (int k = 0; k < 3; k++)
            if (s_valid[k] && s_ready[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        @(posedge i_clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = (i == 0) ? CH9350_HDR0 : (i == 1) ? CH9350_HDR1 : 8'($urandom);
            src_q[p].push_back({(i == len - 1), d});
        end
    endtask

    task automatic exp_from_queue(input int p);
        foreach (src_q[p][i]) begin
            exp_q.push_back({2'(p), src_q[p][i][7:0]});
            exp_last.push_back(src_q[p][i][8]);
        end
    endtask

    // Whole-packet round robin over the queued packets: first non-empty port at/after pointer
    task automatic model_build();
        logic [8:0] mq[3][$];
        for (int k = 0; k < 3; k++) mq[k] = src_q[k];
        forever begin
            int p;
            bit done;
            p = -1;
            for (int i = 0; i < 3; i++) begin
                int k;
                k = (model_ptr + i) % 3;
                if (p < 0 && mq[k].size() > 0) p = k;
            end
            if (p < 0) break;
            done = 1'b0;
            while (!done) begin
                logic [8:0] b;
                b = mq[p].pop_front();
                exp_q.push_back({p[1:0], b[7:0]});
                exp_last.push_back(b[8]);
                if (b[8] || mq[p].size() == 0) done = 1'b1;
            end
            model_ptr = (p + 1) % 3;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); obs_cyc.delete(); exp_q.delete(); exp_last.delete();
    endtask

    task automatic drain(input int bound);
        int c;
        c = 0;
        while ((busy || pending()) && c < bound) begin step(); c++; end
        checks++;
        if (c >= bound) begin
            errors++;
            $display("FAIL drain_bound: still busy after %0d cycles, required idle", c);
        end
    endtask

    task automatic test_reset();
        clear_obs();
        tready_mode = 0;
        for (int k = 0; k < 3; k++) begin en[k] = 1'b1; add_pkt(k, 1); end
        model_ptr = 0;
        model_build();
        drive();
        repeat (3) step();
        checks++;
        if ({grant, s_ready, m_valid, busy, tmo} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000000", {grant, s_ready, m_valid, busy, tmo});
        end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1; cyc++; drive();
        checks++;
        if (grant !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got grant=%b busy=%b required 001/1", grant, busy);
        end
        drain(50);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_count: got %0d bytes required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_three_ports();
        clear_obs();
        tready_mode = 0;
        for (int k = 0; k < 3; k++) add_pkt(k, 3);
        model_build();
        drive();
        drain(60);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL three_count: got %0d bytes required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL three_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
            if (i > 0) begin
                checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != (exp_last[i-1] ? 2 : 1)) begin
                    errors++;
                    $display("FAIL three_gap%0d: got %0d cycles required %0d", i,
                             obs_cyc[i] - obs_cyc[i-1], exp_last[i-1] ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_single_byte();
        clear_obs();
        tready_mode = 0;
        src_q[1].push_back({1'b1, 8'h2C});
        model_build();
        drive();
        drain(20);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 10'h12C) begin
            errors++;
            $display("FAIL single_byte: got %0d bytes first %h required 1 byte 12c", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0] : 10'h3FF);
        end
        clear_obs();
        add_pkt(0, 1 + $urandom % 3);
        add_pkt(2, 1 + $urandom % 3);
        model_build();
        drive();
        drain(40);
        checks++;
        if (obs_q.size() == 0 || obs_q[0][9:8] !== 2'd2) begin
            errors++;
            $display("FAIL single_next_owner: got port %0d required 2", obs_q.size() > 0 ? obs_q[0][9:8] : 3);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_follow%0d: got %h required %h", i,
                         i < obs_q.size() ? obs_q[i] : 10'h3FF, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        clear_obs();
        tready_mode = 1;
        add_pkt(0, 4);
        exp_from_queue(0);
        drive();
        c = 0;
        while (!(busy && grant == 3'b001) && c < 10) begin step(); c++; end
        add_pkt(2, 2);
        exp_from_queue(2);
        model_ptr = 0;
        drive();
        drain(80);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        tready_mode = 2;
        for (int r = 0; r < 5; r++) begin
            clear_obs();
            for (int k = 0; k < 3; k++)
                if ($urandom % 2) repeat (1 + $urandom % 2) add_pkt(k, 1 + $urandom % 4);
            if (!pending()) add_pkt($urandom % 3, 1 + $urandom % 4);
            model_build();
            drive();
            drain(400);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d bytes required %0d", r, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d: got %h required %h", r, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int c;
        clear_obs();
        tready_mode = 0;
        add_pkt(0, 3);
        exp_from_queue(0);
        drive();
        c = 0;
        while (obs_q.size() < 1 && c < 20) begin step(); c++; end
        en[0] = 1'b0;
        add_pkt(1, 2);
        exp_from_queue(1);
        drive();
`ifndef ARB_TIMEOUT_EN
        repeat (2000) step();
        checks++;
        if (grant !== 3'b001 || obs_q.size() != 1 || s_ready[1] !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got grant=%b bytes=%0d ready1=%b mvalid=%b required 001/1/0/0",
                     grant, obs_q.size(), s_ready[1], m_valid);
        end
        en[0] = 1'b1;
        drive();
        drain(40);
        model_ptr = 2;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d bytes required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
`else
        begin
            int pulses;
            bit p1_seen;
            pulses = 0;
            p1_seen = 1'b0;
            repeat (2000) begin
                step();
                if (tmo) pulses++;
            end
            foreach (obs_q[i]) if (obs_q[i][9:8] == 2'd1) p1_seen = 1'b1;
            checks++;
            if (pulses != 1 || !p1_seen) begin
                errors++;
                $display("FAIL stall_timeout: got pulses=%0d port1_served=%0d required 1/1", pulses, p1_seen);
            end
            en[0] = 1'b1;
            drive();
            drain(40);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c;
        clear_obs();
        tready_mode = 0;
        add_pkt(0, 3);
        drive();
        c = 0;
        while (obs_q.size() < 2 && c < 20) begin step(); c++; end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, s_ready, m_valid, busy, tmo} !== 9'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got %b data %h required all zero",
                     {grant, s_ready, m_valid, busy, tmo}, m_data);
        end
        for (int k = 0; k < 3; k++) src_q[k].delete();
        repeat (2) step();
        i_rst_n = 1'b1;
        clear_obs();
        model_ptr = 0;
        add_pkt(0, 1);
        add_pkt(2, 1);
        model_build();
        drive();
        drain(30);
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_restart%0d: got %h required %h", i,
                         i < obs_q.size() ? obs_q[i] : 10'h3FF, exp_q[i]);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        @(posedge i_clk); #1;
        test_reset();
        test_three_ports();
        test_single_byte();
        test_backpressure();
        test_random();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
